// File: rtl/crtc_regs.sv
// 6845-style CRTC register file: CPU writes land in a shadow bank, which is
// copied to the active bank driving video_gen on each rising edge of v_sync.
module crtc_regs #(
    parameter logic [7:0] R0_DEFAULT = 8'd49,
    parameter logic [7:0] R1_DEFAULT = 8'd40,
    parameter logic [7:0] R2_DEFAULT = 8'd41,
    parameter logic [7:0] R3_DEFAULT = 8'h1F,
    parameter logic [6:0] R4_DEFAULT = 7'd40,
    parameter logic [4:0] R5_DEFAULT = 5'd5,
    parameter logic [6:0] R6_DEFAULT = 7'd25,
    parameter logic [6:0] R7_DEFAULT = 7'd33,
    parameter logic [4:0] R9_DEFAULT = 5'd7
) (
    input  logic       clk16,
    input  logic       reset_n,
    input  logic       crtc_select,
    input  logic       cpu_strobe,
    input  logic       cpu_rw,
    input  logic       rs,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       v_sync,
    output logic [7:0] h_char_total,
    output logic [7:0] h_char_displayed,
    output logic [7:0] h_sync_pos,
    output logic [3:0] h_sync_width,
    output logic [3:0] v_sync_width,
    output logic [6:0] v_char_total,
    output logic [4:0] v_adjust,
    output logic [6:0] v_char_displayed,
    output logic [6:0] v_sync_pos,
    output logic [4:0] v_char_height,
    output logic       update_pending
);

    // Bus handshake: one access per rising edge of cpu_strobe while
    // crtc_select is high; a strobe held for many cycles is still one access.
    logic       strobe_d;
    logic       vsync_d;
    logic [4:0] index;
    logic [7:0] sh_r0, sh_r1, sh_r2, sh_r3;
    logic [6:0] sh_r4, sh_r6, sh_r7;
    logic [4:0] sh_r5, sh_r9;
    logic [7:0] shadow_rd;
    logic       access;
    logic       commit;
    logic       index_valid;

    assign access      = crtc_select & cpu_strobe & ~strobe_d;
    assign commit      = v_sync & ~vsync_d;
    assign index_valid = (index <= 5'd7) || (index == 5'd9);

    always_comb begin
        shadow_rd = 8'h00;
        case (index)
            5'd0: shadow_rd = sh_r0;
            5'd1: shadow_rd = sh_r1;
            5'd2: shadow_rd = sh_r2;
            5'd3: shadow_rd = sh_r3;
            5'd4: shadow_rd = {1'b0, sh_r4};
            5'd5: shadow_rd = {3'b000, sh_r5};
            5'd6: shadow_rd = {1'b0, sh_r6};
            5'd7: shadow_rd = {1'b0, sh_r7};
            5'd9: shadow_rd = {3'b000, sh_r9};
            default: shadow_rd = 8'h00;
        endcase
    end

    always_ff @(posedge clk16) begin
        if (!reset_n) begin
            strobe_d         <= 1'b1;
            vsync_d          <= 1'b1;
            index            <= 5'd0;
            data_out         <= 8'h00;
            update_pending   <= 1'b0;
            sh_r0            <= R0_DEFAULT;
            sh_r1            <= R1_DEFAULT;
            sh_r2            <= R2_DEFAULT;
            sh_r3            <= R3_DEFAULT;
            sh_r4            <= R4_DEFAULT;
            sh_r5            <= R5_DEFAULT;
            sh_r6            <= R6_DEFAULT;
            sh_r7            <= R7_DEFAULT;
            sh_r9            <= R9_DEFAULT;
            h_char_total     <= R0_DEFAULT;
            h_char_displayed <= R1_DEFAULT;
            h_sync_pos       <= R2_DEFAULT;
            h_sync_width     <= R3_DEFAULT[3:0];
            v_sync_width     <= R3_DEFAULT[7:4];
            v_char_total     <= R4_DEFAULT;
            v_adjust         <= R5_DEFAULT;
            v_char_displayed <= R6_DEFAULT;
            v_sync_pos       <= R7_DEFAULT;
            v_char_height    <= R9_DEFAULT;
        end else begin
            strobe_d <= cpu_strobe;
            vsync_d  <= v_sync;

            // Commit uses the pre-write shadow; a same-cycle write below
            // re-arms update_pending so it lands at the next frame.
            if (commit) begin
                h_char_total     <= sh_r0;
                h_char_displayed <= sh_r1;
                h_sync_pos       <= sh_r2;
                h_sync_width     <= sh_r3[3:0];
                v_sync_width     <= sh_r3[7:4];
                v_char_total     <= sh_r4;
                v_adjust         <= sh_r5;
                v_char_displayed <= sh_r6;
                v_sync_pos       <= sh_r7;
                v_char_height    <= sh_r9;
                update_pending   <= 1'b0;
            end

            if (access && !cpu_rw && !rs) begin
                index <= data_in[4:0];
            end

            if (access && !cpu_rw && rs && index_valid) begin
                case (index)
                    5'd0: sh_r0 <= data_in;
                    5'd1: sh_r1 <= data_in;
                    5'd2: sh_r2 <= data_in;
                    5'd3: sh_r3 <= data_in;
                    5'd4: sh_r4 <= data_in[6:0];
                    5'd5: sh_r5 <= data_in[4:0];
                    5'd6: sh_r6 <= data_in[6:0];
                    5'd7: sh_r7 <= data_in[6:0];
                    5'd9: sh_r9 <= data_in[4:0];
                    default: ;
                endcase
                update_pending <= 1'b1;
            end

            if (access && cpu_rw) begin
                data_out <= rs ? shadow_rd : {update_pending, 2'b00, index};
            end
        end
    end

endmodule

// File: tb/tb_crtc_regs.sv
// Directed bench for crtc_regs: drivers push expected values into a queue,
// and a negedge monitor pops and compares them against the selected output.
module tb_crtc_regs;

    logic       clk16 = 1'b0;
    logic       reset_n;
    logic       crtc_select;
    logic       cpu_strobe;
    logic       cpu_rw;
    logic       rs;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       v_sync;
    logic [7:0] h_char_total;
    logic [7:0] h_char_displayed;
    logic [7:0] h_sync_pos;
    logic [3:0] h_sync_width;
    logic [3:0] v_sync_width;
    logic [6:0] v_char_total;
    logic [4:0] v_adjust;
    logic [6:0] v_char_displayed;
    logic [6:0] v_sync_pos;
    logic [4:0] v_char_height;
    logic       update_pending;

    localparam int S_DOUT = 0, S_HCT = 1, S_HCD = 2, S_HSP = 3, S_HSW = 4,
                   S_VSW = 5, S_VCT = 6, S_VADJ = 7, S_VCD = 8, S_VSP = 9,
                   S_VCH = 10, S_PEND = 11;

    logic [7:0] exp_q[$];
    int         sel_q[$];
    string      name_q[$];
    int         checks = 0;
    int         failures = 0;

    crtc_regs dut (
        .clk16            (clk16),
        .reset_n          (reset_n),
        .crtc_select      (crtc_select),
        .cpu_strobe       (cpu_strobe),
        .cpu_rw           (cpu_rw),
        .rs               (rs),
        .data_in          (data_in),
        .data_out         (data_out),
        .v_sync           (v_sync),
        .h_char_total     (h_char_total),
        .h_char_displayed (h_char_displayed),
        .h_sync_pos       (h_sync_pos),
        .h_sync_width     (h_sync_width),
        .v_sync_width     (v_sync_width),
        .v_char_total     (v_char_total),
        .v_adjust         (v_adjust),
        .v_char_displayed (v_char_displayed),
        .v_sync_pos       (v_sync_pos),
        .v_char_height    (v_char_height),
        .update_pending   (update_pending)
    );

    // clock / reset
    always #5 clk16 = ~clk16;

    function automatic logic [7:0] get_out(input int sel);
        case (sel)
            S_DOUT:  return data_out;
            S_HCT:   return h_char_total;
            S_HCD:   return h_char_displayed;
            S_HSP:   return h_sync_pos;
            S_HSW:   return {4'h0, h_sync_width};
            S_VSW:   return {4'h0, v_sync_width};
            S_VCT:   return {1'b0, v_char_total};
            S_VADJ:  return {3'b000, v_adjust};
            S_VCD:   return {1'b0, v_char_displayed};
            S_VSP:   return {1'b0, v_sync_pos};
            S_VCH:   return {3'b000, v_char_height};
            default: return {7'h00, update_pending};
        endcase
    endfunction

    // scoreboard monitor: outputs are stable at the falling edge
    always @(negedge clk16) begin
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            logic [7:0] a;
            int         s;
            string      n;
            e = exp_q.pop_front();
            s = sel_q.pop_front();
            n = name_q.pop_front();
            a = get_out(s);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s: got 0x%02h expected 0x%02h", n, a, e);
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk16);
        #1;
    endtask

    task automatic expect_out(input int sel, input logic [7:0] e, input string n);
        exp_q.push_back(e);
        sel_q.push_back(sel);
        name_q.push_back(n);
    endtask

    task automatic bus_cycle(input logic rw, input logic r, input logic [7:0] d);
        crtc_select = 1'b1;
        cpu_strobe  = 1'b1;
        cpu_rw      = rw;
        rs          = r;
        data_in     = d;
        tick();
        cpu_strobe  = 1'b0;
        crtc_select = 1'b0;
        tick();
    endtask

    task automatic write_reg(input logic [7:0] idx, input logic [7:0] d);
        bus_cycle(1'b0, 1'b0, idx);
        bus_cycle(1'b0, 1'b1, d);
    endtask

    task automatic frame();
        v_sync = 1'b1;
        tick();
    endtask

    task automatic frame_end();
        v_sync = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; crtc_select = 1'b0; cpu_strobe = 1'b0;
        cpu_rw = 1'b0; rs = 1'b0; data_in = 8'h00; v_sync = 1'b0;
        do_reset();
        expect_out(S_HCT,  8'd49, "reset_hct");
        expect_out(S_VCH,  8'd7,  "reset_vch");
        expect_out(S_HSW,  8'hF,  "reset_hsw");
        expect_out(S_VSW,  8'h1,  "reset_vsw");
        expect_out(S_DOUT, 8'h00, "reset_dout");
        expect_out(S_PEND, 8'h0,  "reset_pend");
        tick();

        // index/data write then commit
        write_reg(8'd1, 8'd3);
        expect_out(S_HCD,  8'd40, "hcd_before_commit");
        expect_out(S_PEND, 8'h1,  "pend_after_write");
        frame();
        expect_out(S_HCD,  8'd3,  "hcd_after_commit");
        expect_out(S_PEND, 8'h0,  "pend_after_commit");
        frame_end();

        // long strobe; data_in changes mid-strobe so a repeat access would show
        crtc_select = 1'b1; cpu_strobe = 1'b1; cpu_rw = 1'b0; rs = 1'b0;
        data_in = 8'h02;
        tick();
        data_in = 8'h05;
        repeat (4) tick();
        cpu_strobe = 1'b0; crtc_select = 1'b0;
        tick();
        bus_cycle(1'b1, 1'b0, 8'h00);
        expect_out(S_DOUT, 8'h02, "index_read_clear");
        bus_cycle(1'b0, 1'b1, 8'h10);
        bus_cycle(1'b1, 1'b0, 8'h00);
        expect_out(S_DOUT, 8'h82, "index_read_pending");
        bus_cycle(1'b1, 1'b1, 8'h00);
        expect_out(S_DOUT, 8'h10, "shadow_read_r2");
        expect_out(S_HSP,  8'd41, "hsp_before_commit");
        frame();
        expect_out(S_HSP,  8'h10, "hsp_after_commit");
        frame_end();

        // truncation
        write_reg(8'd5, 8'hFF);
        bus_cycle(1'b1, 1'b1, 8'h00);
        expect_out(S_DOUT, 8'h1F, "shadow_read_r5_trunc");
        write_reg(8'd9, 8'hE3);
        frame();
        expect_out(S_VADJ, 8'h1F, "vadj_trunc");
        expect_out(S_VCH,  8'h03, "vch_trunc");
        frame_end();

        // invalid index 8
        write_reg(8'd8, 8'hAA);
        expect_out(S_PEND, 8'h0,  "pend_idx8");
        bus_cycle(1'b1, 1'b1, 8'h00);
        expect_out(S_DOUT, 8'h00, "read_idx8");
        frame();
        expect_out(S_HCT,  8'd49, "hct_idx8");
        expect_out(S_VADJ, 8'h1F, "vadj_idx8");
        frame_end();

        // write to R0 in the same cycle as commit
        bus_cycle(1'b0, 1'b0, 8'd0);
        crtc_select = 1'b1; cpu_strobe = 1'b1; cpu_rw = 1'b0; rs = 1'b1;
        data_in = 8'd7; v_sync = 1'b1;
        tick();
        expect_out(S_HCT,  8'd49, "hct_collision");
        expect_out(S_PEND, 8'h1,  "pend_collision");
        cpu_strobe = 1'b0; crtc_select = 1'b0;
        frame_end();
        frame();
        expect_out(S_HCT,  8'd7,  "hct_next_frame");
        expect_out(S_PEND, 8'h0,  "pend_next_frame");
        frame_end();

        // reset mid-frame discards shadow write
        write_reg(8'd4, 8'd6);
        expect_out(S_PEND, 8'h1,  "pend_r4");
        tick();
        do_reset();
        expect_out(S_VCT,  8'd40, "vct_after_reset");
        expect_out(S_PEND, 8'h0,  "pend_after_reset");
        expect_out(S_HCT,  8'd49, "hct_after_reset");
        tick();
        frame();
        expect_out(S_VCT,  8'd40, "vct_after_frame");
        frame_end();

        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crtc_regs.md
Name: crtc_regs

Overview:
- 6845-style CRTC register file that configures the video_gen timing inputs from CPU bus cycles.
- The CPU writes an index register and then a data register. Data writes land in a shadow bank.
- The shadow bank is committed to the active bank driving video_gen at the next frame boundary (rising edge of v_sync), so mid-frame writes never tear the raster.
- Sits between the bus decode (crtc_select, cpu_strobe) and video_gen's configuration ports.

Parameters:
- R0_DEFAULT, 8'd49, reset value of h_char_total
- R1_DEFAULT, 8'd40, reset value of h_char_displayed
- R2_DEFAULT, 8'd41, reset value of h_sync_pos
- R3_DEFAULT, 8'h1F, reset sync widths ([3:0] h_sync_width, [7:4] v_sync_width)
- R4_DEFAULT, 7'd40, reset value of v_char_total
- R5_DEFAULT, 5'd5, reset value of v_adjust
- R6_DEFAULT, 7'd25, reset value of v_char_displayed
- R7_DEFAULT, 7'd33, reset value of v_sync_pos
- R9_DEFAULT, 5'd7, reset value of v_char_height

Ports:
- clk16  in  1  16 MHz system clock; all logic on its rising edge
- reset_n  in  1  synchronous, active-low reset
- crtc_select  in  1  CRTC chip select from address decode
- cpu_strobe  in  1  CPU bus strobe; may stay high for several clk16 cycles
- cpu_rw  in  1  1 = read, 0 = write
- rs  in  1  register select: 0 = index register, 1 = data register
- data_in  in  8  CPU write data
- data_out  out  8  registered CPU read data
- v_sync  in  1  vertical sync from video_gen; frame-boundary reference
- h_char_total  out  8  active R0
- h_char_displayed  out  8  active R1
- h_sync_pos  out  8  active R2
- h_sync_width  out  4  active R3[3:0]
- v_sync_width  out  4  active R3[7:4]
- v_char_total  out  7  active R4[6:0]
- v_adjust  out  5  active R5[4:0]
- v_char_displayed  out  7  active R6[6:0]
- v_sync_pos  out  7  active R7[6:0]
- v_char_height  out  5  active R9[4:0]
- update_pending  out  1  shadow holds uncommitted writes

Behaviour:
- Reset (reset_n low at a clk16 edge):
  - Shadow and active banks load *_DEFAULT.
  - index = 0, data_out = 0, update_pending = 0.
  - Edge-detect history for cpu_strobe and v_sync is set to 1, so no spurious access or commit occurs on the first cycle after reset.
  - Reset mid-access or mid-frame discards all state.
- Access detection:
  - access = crtc_select & cpu_strobe & ~strobe_d, where strobe_d is cpu_strobe registered.
  - Exactly one access per strobe assertion, however long cpu_strobe stays high.
- Write, rs = 0: index <= data_in[4:0].
- Write, rs = 1:
  - If index ∈ {0–7, 9}: shadow[index] <= data_in truncated to the field width, and update_pending <= 1.
  - Any other index: write ignored, pending unchanged.
- Read, rs = 0: data_out <= {update_pending, 2'b00, index}, one cycle after the access edge.
- Read, rs = 1: data_out <= shadow[index] zero-extended for index ∈ {0–7, 9}; 8'h00 otherwise. Reads have no side effects.
- Frame commit:
  - commit = v_sync & ~v_sync_d.
  - On commit, every active register <= its shadow value and update_pending <= 0.
  - Outputs change on the clk16 edge after the v_sync rise is sampled (1-cycle latency).
- Simultaneous commit and data write in the same cycle:
  - Active takes the pre-write shadow value.
  - The shadow takes the new value.
  - update_pending stays 1, so the new value commits at the following frame.
- Commit with update_pending = 0 is harmless (active already equals shadow).
- v_sync is assumed synchronous to clk16 (video_gen is clocked from it); no extra synchronizer.
- Active outputs are direct register outputs: glitch-free and stable between commits.

Test Plan:
- Reset: hold reset_n low for 2 cycles -> h_char_total = 49, v_char_height = 7, h_sync_width = 4'hF, v_sync_width = 4'h1, data_out = 0, update_pending = 0.
- Index/data write, then commit: write index 1, write data 8'd3 -> h_char_displayed stays 40 and update_pending = 1. Pulse v_sync -> h_char_displayed = 3 one cycle after the rise, update_pending = 0.
- Long strobe: hold cpu_strobe high for 5 cycles on a rs = 0 write of 8'h02 -> exactly one access. Then a rs = 0 read returns 8'h82 when pending is set, 8'h02 when clear.
- Truncation and invalid index:
  - index 5, data 8'hFF -> after commit v_adjust = 5'h1F.
  - index 8, data 8'hAA -> no pending, no output change.
  - data read at index 8 -> 8'h00.
- Same-cycle collision: data write of 8'd7 to R0 in the exact cycle of commit -> h_char_total unchanged, update_pending = 1. Next v_sync rise -> h_char_total = 7.
- Reset mid-frame: write R4 = 6, assert reset_n low before v_sync -> v_char_total = 40, update_pending = 0; the following v_sync leaves v_char_total = 40.
